// File: rtl/fetch_pc_gen_if.sv
`default_nettype none
// ============================================================================
// fetch_pc_gen_if : fetch next-PC generator interface (redirects, BTB/predictor
//                   inputs, fetch PC, slot mask, RAS and miss outputs)
// Revision 1.0
// ============================================================================
interface fetch_pc_gen_if #(
  parameter int FETCH_WIDTH = 4,
  parameter int SIZE_PC     = 32,
  parameter int RAS_DEPTH   = 16
);
  localparam int PTR_W = $clog2(RAS_DEPTH);

  logic                           stall_i;
  logic                           recoverFlag_i;
  logic [SIZE_PC-1:0]             recoverPC_i;
  logic                           exceptionFlag_i;
  logic [SIZE_PC-1:0]             exceptionPC_i;
  logic                           flagRecoverEX_i;
  logic [SIZE_PC-1:0]             targetAddrEX_i;
  logic                           flagRecoverID_i;
  logic [SIZE_PC-1:0]             targetAddrID_i;
  logic [PTR_W-1:0]               rasRestorePtr_i;
  logic                           flagCallID_i;
  logic [SIZE_PC-1:0]             callPCID_i;
  logic                           flagRtrID_i;
  logic [FETCH_WIDTH-1:0]         btbHit_i;
  logic [2*FETCH_WIDTH-1:0]       btbCtrlType_i;
  logic [FETCH_WIDTH*SIZE_PC-1:0] btbTarget_i;
  logic [FETCH_WIDTH-1:0]         prediction_i;
  logic                           icacheMiss_i;
  logic                           icacheFill_i;
  logic [SIZE_PC-1:0]             pc_o;
  logic                           fetchValid_o;
  logic [FETCH_WIDTH-1:0]         fetchMask_o;
  logic [PTR_W-1:0]               rasPtr_o;
  logic [SIZE_PC-1:0]             rasTop_o;
  logic                           miss_o;
  logic [SIZE_PC-1:0]             missAddr_o;

  modport master (
    output stall_i, recoverFlag_i, recoverPC_i, exceptionFlag_i, exceptionPC_i,
           flagRecoverEX_i, targetAddrEX_i, flagRecoverID_i, targetAddrID_i,
           rasRestorePtr_i, flagCallID_i, callPCID_i, flagRtrID_i, btbHit_i,
           btbCtrlType_i, btbTarget_i, prediction_i, icacheMiss_i, icacheFill_i,
    input  pc_o, fetchValid_o, fetchMask_o, rasPtr_o, rasTop_o, miss_o, missAddr_o
  );

  modport slave (
    input  stall_i, recoverFlag_i, recoverPC_i, exceptionFlag_i, exceptionPC_i,
           flagRecoverEX_i, targetAddrEX_i, flagRecoverID_i, targetAddrID_i,
           rasRestorePtr_i, flagCallID_i, callPCID_i, flagRtrID_i, btbHit_i,
           btbCtrlType_i, btbTarget_i, prediction_i, icacheMiss_i, icacheFill_i,
    output pc_o, fetchValid_o, fetchMask_o, rasPtr_o, rasTop_o, miss_o, missAddr_o
  );
endinterface
`default_nettype wire

// File: rtl/fetch_pc_gen.sv
`default_nettype none
// ============================================================================
// fetch_pc_gen : PC register, circular return address stack and I-cache
//                miss-wait sequencing for a FETCH_WIDTH-wide fetch block
// Revision 1.0
// ============================================================================
module fetch_pc_gen #(
  parameter int                 FETCH_WIDTH = 4,
  parameter int                 SIZE_PC     = 32,
  parameter int                 INST_BYTES  = 8,
  parameter int                 RAS_DEPTH   = 16,
  parameter logic [SIZE_PC-1:0] RESET_PC    = '0
) (
  input wire            clk,
  input wire            reset,
  fetch_pc_gen_if.slave bus
);
  localparam int BLK   = FETCH_WIDTH * INST_BYTES;
  localparam int OFF_W = $clog2(INST_BYTES);
  localparam int IDX_W = $clog2(FETCH_WIDTH);
  localparam int BLK_W = OFF_W + IDX_W;
  localparam int PTR_W = $clog2(RAS_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    S_RUN       = 2'd0,
    S_MISS_WAIT = 2'd1,
    S_DRAIN     = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [SIZE_PC-1:0] pc_q, pc_d;
  logic               miss_q, miss_d;
  logic [SIZE_PC-1:0] miss_addr_q, miss_addr_d;
  logic [SIZE_PC-1:0] ras_q [RAS_DEPTH];
  logic [SIZE_PC-1:0] ras_d [RAS_DEPTH];
  logic [PTR_W-1:0]   ras_ptr_q, ras_ptr_d;
  logic [CNT_W-1:0]   ras_cnt_q, ras_cnt_d;

  logic [IDX_W-1:0]       start;
  logic [SIZE_PC-1:0]     base;
  logic [FETCH_WIDTH-1:0] taken;
  logic [FETCH_WIDTH-1:0] mask;
  logic                   any_taken;
  logic [IDX_W-1:0]       k_idx;
  logic [1:0]             k_type;
  logic [SIZE_PC-1:0]     k_target;
  logic [SIZE_PC-1:0]     ret_addr;
  logic [SIZE_PC-1:0]     ras_top;
  logic [SIZE_PC-1:0]     next_pc;
  logic                   id_redirect;
  logic                   redirect;
  logic                   advance;
  logic                   do_push;
  logic                   do_pop;
  logic [SIZE_PC-1:0]     push_val;

  // Slot decode: slots below the unaligned start are ignored, k is the first taken slot.
  always_comb begin
    start     = pc_q[OFF_W +: IDX_W];
    base      = {pc_q[SIZE_PC-1:BLK_W], {BLK_W{1'b0}}};
    taken     = '0;
    any_taken = 1'b0;
    k_idx     = '0;
    for (int i = FETCH_WIDTH - 1; i >= 0; i--) begin
      taken[i] = bus.btbHit_i[i]
               & (bus.prediction_i[i] | (bus.btbCtrlType_i[2*i +: 2] != 2'b11))
               & (i >= int'(start));
      if (taken[i]) begin
        any_taken = 1'b1;
        k_idx     = IDX_W'(i);
      end
    end
    mask = '0;
    for (int i = 0; i < FETCH_WIDTH; i++) begin
      mask[i] = (i >= int'(start)) & (~any_taken | (i <= int'(k_idx)));
    end
    k_type   = bus.btbCtrlType_i[2*int'(k_idx) +: 2];
    k_target = bus.btbTarget_i[int'(k_idx)*SIZE_PC +: SIZE_PC];
    ret_addr = base + SIZE_PC'((int'(k_idx) + 1) * INST_BYTES);
    ras_top  = ras_q[ras_ptr_q];
  end

  always_comb begin
    next_pc = base + SIZE_PC'(BLK);
    if (bus.flagRecoverEX_i) begin
      next_pc = bus.targetAddrEX_i;
    end else if (bus.flagRecoverID_i) begin
      next_pc = bus.flagRtrID_i ? ras_q[bus.rasRestorePtr_i] : bus.targetAddrID_i;
    end else if (any_taken) begin
      next_pc = (k_type == 2'b00) ? ras_top : k_target;
    end
  end

  always_comb begin
    id_redirect = bus.flagRecoverID_i & ~bus.stall_i;
    redirect    = bus.recoverFlag_i | bus.exceptionFlag_i | bus.flagRecoverEX_i | id_redirect;
    advance     = ~bus.stall_i & (state_q == S_RUN) & ~bus.icacheMiss_i & ~redirect;

    pc_d = pc_q;
    if (bus.recoverFlag_i)               pc_d = bus.recoverPC_i;
    else if (bus.exceptionFlag_i)        pc_d = bus.exceptionPC_i;
    else if (bus.flagRecoverEX_i)        pc_d = next_pc;
    else if (id_redirect || advance)     pc_d = next_pc;

    state_d     = state_q;
    miss_d      = miss_q;
    miss_addr_d = miss_addr_q;
    case (state_q)
      S_RUN: begin
        if (~bus.stall_i && bus.icacheMiss_i && !redirect) begin
          state_d     = S_MISS_WAIT;
          miss_d      = 1'b1;
          miss_addr_d = base;
        end
      end
      S_MISS_WAIT: begin
        if (bus.icacheFill_i) begin
          state_d = S_RUN;
          miss_d  = 1'b0;
        end else if (redirect) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        // The fill still owed is for the abandoned block; wait it out.
        if (bus.icacheFill_i) begin
          state_d = S_RUN;
          miss_d  = 1'b0;
        end
      end
      default: begin
        state_d = S_RUN;
        miss_d  = 1'b0;
      end
    endcase
  end

  always_comb begin
    ras_d     = ras_q;
    ras_ptr_d = ras_ptr_q;
    ras_cnt_d = ras_cnt_q;
    do_push   = 1'b0;
    do_pop    = 1'b0;
    push_val  = '0;
    if (bus.recoverFlag_i || bus.exceptionFlag_i) begin
      ras_ptr_d = '0;
      ras_cnt_d = '0;
    end else if (id_redirect && !bus.flagRecoverEX_i) begin
      ras_ptr_d = bus.rasRestorePtr_i;
      if (bus.flagCallID_i) begin
        do_push  = 1'b1;
        push_val = bus.callPCID_i;
      end else if (bus.flagRtrID_i) begin
        do_pop = 1'b1;
      end
    end else if (advance && any_taken) begin
      if (k_type == 2'b01) begin
        do_push  = 1'b1;
        push_val = ret_addr;
      end else if (k_type == 2'b00) begin
        do_pop = 1'b1;
      end
    end
    // Full push overwrites the oldest entry; empty pop reuses a stale one.
    if (do_push) begin
      ras_ptr_d        = ras_ptr_d + PTR_W'(1);
      ras_d[ras_ptr_d] = push_val;
      if (ras_cnt_d != CNT_W'(RAS_DEPTH)) ras_cnt_d = ras_cnt_d + CNT_W'(1);
    end else if (do_pop) begin
      ras_ptr_d = ras_ptr_d - PTR_W'(1);
      if (ras_cnt_d != '0) ras_cnt_d = ras_cnt_d - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_RUN;
      pc_q        <= RESET_PC;
      miss_q      <= 1'b0;
      miss_addr_q <= '0;
      ras_q       <= '{default: '0};
      ras_ptr_q   <= '0;
      ras_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      miss_q      <= miss_d;
      miss_addr_q <= miss_addr_d;
      ras_q       <= ras_d;
      ras_ptr_q   <= ras_ptr_d;
      ras_cnt_q   <= ras_cnt_d;
    end
  end

  assign bus.pc_o         = pc_q;
  assign bus.fetchValid_o = (state_q == S_RUN) & ~bus.icacheMiss_i & ~bus.stall_i;
  assign bus.fetchMask_o  = mask;
  assign bus.rasPtr_o     = ras_ptr_q;
  assign bus.rasTop_o     = ras_top;
  assign bus.miss_o       = miss_q;
  assign bus.missAddr_o   = miss_addr_q;
endmodule
`default_nettype wire

// File: tb/tb_fetch_pc_gen.sv
`default_nettype none
// ============================================================================
// tb_fetch_pc_gen : vector table, directed corner sequences and random
//                   stimulus against a behavioural next-PC/RAS/miss model
// Revision 1.0
// ============================================================================
module tb_fetch_pc_gen;
  localparam int FW    = 4;
  localparam int PCW   = 32;
  localparam int IB    = 8;
  localparam int DEPTH = 16;
  localparam int BLK   = FW * IB;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  fetch_pc_gen_if #(.FETCH_WIDTH(FW), .SIZE_PC(PCW), .RAS_DEPTH(DEPTH)) bus ();

  fetch_pc_gen #(
    .FETCH_WIDTH(FW), .SIZE_PC(PCW), .INST_BYTES(IB), .RAS_DEPTH(DEPTH), .RESET_PC(32'h0)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  int tests = 0;
  int fails = 0;

  // Behavioural model: a stack array, a pointer, an occupancy count and one
  // "fill owed" flag (waiting and draining look identical from the outside).
  logic [31:0] m_pc;
  logic [31:0] m_ras [DEPTH];
  int          m_ptr;
  int          m_cnt;
  bit          m_wait;
  logic [31:0] m_missaddr;

  typedef struct {
    logic [31:0] pc;
    logic [3:0]  hit;
    logic [7:0]  typ;
    logic [3:0]  pred;
    logic [31:0] tb;
    logic [3:0]  mask;
    logic [31:0] npc;
  } vec_t;
  vec_t vecs [8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [127:0] mk_tgts(input logic [31:0] b);
    return {b + 32'h30, b + 32'h20, b + 32'h10, b};
  endfunction

  function automatic int find_k();
    int s;
    s = int'((m_pc / IB) % FW);
    for (int i = s; i < FW; i++) begin
      if (bus.btbHit_i[i] && (bus.prediction_i[i] || bus.btbCtrlType_i[2*i +: 2] != 2'b11))
        return i;
    end
    return -1;
  endfunction

  function automatic logic [3:0] exp_mask(input int k);
    logic [3:0] m;
    int s, last;
    s = int'((m_pc / IB) % FW);
    last = (k < 0) ? FW - 1 : k;
    m = '0;
    for (int i = s; i <= last; i++) m[i] = 1'b1;
    return m;
  endfunction

  task automatic model_reset();
    m_pc = 32'h0;
    for (int i = 0; i < DEPTH; i++) m_ras[i] = 32'h0;
    m_ptr = 0;
    m_cnt = 0;
    m_wait = 1'b0;
    m_missaddr = 32'h0;
  endtask

  task automatic m_push(input logic [31:0] v);
    m_ptr = (m_ptr + 1) % DEPTH;
    m_ras[m_ptr] = v;
    if (m_cnt < DEPTH) m_cnt++;
  endtask

  task automatic m_pop();
    m_ptr = (m_ptr + DEPTH - 1) % DEPTH;
    if (m_cnt > 0) m_cnt--;
  endtask

  task automatic model_step();
    int k;
    logic [31:0] base, tgt, npc;
    logic [1:0] ty;
    bit id_ok, redir, adv;
    if (reset) begin
      model_reset();
      return;
    end
    k = find_k();
    base = m_pc & ~(BLK - 1);
    ty = (k >= 0) ? bus.btbCtrlType_i[2*k +: 2] : 2'b00;
    id_ok = bus.flagRecoverID_i && !bus.stall_i;
    redir = bus.recoverFlag_i || bus.exceptionFlag_i || bus.flagRecoverEX_i || id_ok;
    adv = !bus.stall_i && !m_wait && !bus.icacheMiss_i && !redir;
    if (bus.flagRecoverEX_i) tgt = bus.targetAddrEX_i;
    else if (bus.flagRecoverID_i) tgt = bus.flagRtrID_i ? m_ras[bus.rasRestorePtr_i] : bus.targetAddrID_i;
    else if (k >= 0) tgt = (ty == 2'b00) ? m_ras[m_ptr] : bus.btbTarget_i[32*k +: 32];
    else tgt = base + BLK;
    if (bus.recoverFlag_i) npc = bus.recoverPC_i;
    else if (bus.exceptionFlag_i) npc = bus.exceptionPC_i;
    else if (bus.flagRecoverEX_i || id_ok || adv) npc = tgt;
    else npc = m_pc;
    if (bus.recoverFlag_i || bus.exceptionFlag_i) begin
      m_ptr = 0;
      m_cnt = 0;
    end else if (bus.flagRecoverEX_i) begin
      // execute-stage redirect leaves the stack alone
    end else if (id_ok) begin
      m_ptr = int'(bus.rasRestorePtr_i);
      if (bus.flagCallID_i) m_push(bus.callPCID_i);
      else if (bus.flagRtrID_i) m_pop();
    end else if (adv && k >= 0) begin
      if (ty == 2'b01) m_push(base + 32'((k + 1) * IB));
      else if (ty == 2'b00) m_pop();
    end
    if (!m_wait) begin
      if (!bus.stall_i && bus.icacheMiss_i && !redir) begin
        m_wait = 1'b1;
        m_missaddr = base;
      end
    end else if (bus.icacheFill_i) begin
      m_wait = 1'b0;
    end
    m_pc = npc;
  endtask

  task automatic check_model();
    chk("pc", bus.pc_o, m_pc);
    chk("mask", bus.fetchMask_o, exp_mask(find_k()));
    chk("valid", bus.fetchValid_o, !m_wait && !bus.icacheMiss_i && !bus.stall_i);
    chk("ras_ptr", bus.rasPtr_o, m_ptr);
    chk("ras_top", bus.rasTop_o, m_ras[m_ptr]);
    chk("miss", bus.miss_o, m_wait);
    chk("miss_addr", bus.missAddr_o, m_missaddr);
  endtask

  task automatic cycle();
    @(negedge clk);
    check_model();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.stall_i = 0;         bus.recoverFlag_i = 0;   bus.recoverPC_i = '0;
    bus.exceptionFlag_i = 0; bus.exceptionPC_i = '0;  bus.flagRecoverEX_i = 0;
    bus.targetAddrEX_i = '0; bus.flagRecoverID_i = 0; bus.targetAddrID_i = '0;
    bus.rasRestorePtr_i = '0; bus.flagCallID_i = 0;   bus.callPCID_i = '0;
    bus.flagRtrID_i = 0;     bus.btbHit_i = '0;       bus.btbCtrlType_i = '0;
    bus.btbTarget_i = '0;    bus.prediction_i = '0;   bus.icacheMiss_i = 0;
    bus.icacheFill_i = 0;
  endtask

  task automatic load_pc(input logic [31:0] p);
    clear_inputs();
    bus.recoverFlag_i = 1;
    bus.recoverPC_i = p;
    cycle();
    clear_inputs();
  endtask

  initial begin
    vecs[0] = '{32'h00,       4'b0000, 8'h00, 4'b0000, 32'h000, 4'b1111, 32'h020};
    vecs[1] = '{32'h48,       4'b0100, 8'h30, 4'b0100, 32'h0E0, 4'b0110, 32'h100};
    vecs[2] = '{32'h48,       4'b0100, 8'h30, 4'b0000, 32'h0E0, 4'b1110, 32'h060};
    vecs[3] = '{32'h50,       4'b0001, 8'h02, 4'b0000, 32'h700, 4'b1100, 32'h060};
    vecs[4] = '{32'h00,       4'b1010, 8'h88, 4'b0000, 32'h400, 4'b0011, 32'h410};
    vecs[5] = '{32'h18,       4'b1000, 8'hC0, 4'b1000, 32'h400, 4'b1000, 32'h430};
    vecs[6] = '{32'hFFFFFFE8, 4'b0000, 8'h00, 4'b0000, 32'h000, 4'b1110, 32'h000};
    vecs[7] = '{32'h40,       4'b0010, 8'h04, 4'b0000, 32'h1F0, 4'b0011, 32'h200};

    clear_inputs();
    reset = 1;
    @(posedge clk);
    #1;
    model_reset();
    cycle();
    reset = 0;
    chk("reset_pc", bus.pc_o, 32'h0);
    chk("reset_ras_top", bus.rasTop_o, 32'h0);
    chk("reset_miss", bus.miss_o, 1'b0);
    #2 chk("reset_mask", bus.fetchMask_o, 4'b1111);
    cycle();
    chk("seq_pc1", bus.pc_o, 32'h20);
    cycle();
    chk("seq_pc2", bus.pc_o, 32'h40);

    for (int v = 0; v < 8; v++) begin
      load_pc(vecs[v].pc);
      bus.btbHit_i = vecs[v].hit;
      bus.btbCtrlType_i = vecs[v].typ;
      bus.prediction_i = vecs[v].pred;
      bus.btbTarget_i = mk_tgts(vecs[v].tb);
      #2 chk($sformatf("vec%0d_mask", v), bus.fetchMask_o, vecs[v].mask);
      cycle();
      chk($sformatf("vec%0d_next_pc", v), bus.pc_o, vecs[v].npc);
    end

    // call at 0x40 slot 1, then return from 0x200 slot 0
    load_pc(32'h40);
    bus.btbHit_i = 4'b0010; bus.btbCtrlType_i = 8'h04; bus.btbTarget_i = mk_tgts(32'h1F0);
    cycle();
    chk("call_pc", bus.pc_o, 32'h200);
    chk("call_ptr", bus.rasPtr_o, 4'd1);
    chk("call_top", bus.rasTop_o, 32'h50);
    bus.btbHit_i = 4'b0001; bus.btbCtrlType_i = 8'h00;
    cycle();
    chk("ret_pc", bus.pc_o, 32'h50);
    chk("ret_ptr", bus.rasPtr_o, 4'd0);

    // 17 calls overflow the 16-entry stack, 17 returns underflow it
    load_pc(32'h0);
    for (int n = 0; n < 17; n++) begin
      bus.btbHit_i = 4'b0001; bus.btbCtrlType_i = 8'h01;
      bus.btbTarget_i = mk_tgts(32'h1000 * (n + 1));
      cycle();
    end
    chk("ovf_ptr", bus.rasPtr_o, 4'd1);
    for (int j = 0; j < 17; j++) begin
      bus.btbHit_i = 4'b1111; bus.btbCtrlType_i = 8'h00;
      cycle();
      chk($sformatf("lifo_ret%0d", j), bus.pc_o,
          (j < 16) ? 32'h1000 * (16 - j) + 8 : 32'h10008);
    end
    chk("unf_ptr", bus.rasPtr_o, 4'd0);
    clear_inputs();

    // miss at 0x80, EX redirect while waiting, fill five cycles later
    load_pc(32'h80);
    bus.icacheMiss_i = 1;
    #2 chk("miss_valid", bus.fetchValid_o, 1'b0);
    cycle();
    chk("miss_set", bus.miss_o, 1'b1);
    chk("miss_addr", bus.missAddr_o, 32'h80);
    bus.icacheMiss_i = 0;
    bus.flagRecoverEX_i = 1; bus.targetAddrEX_i = 32'h300;
    cycle();
    bus.flagRecoverEX_i = 0;
    chk("drain_pc", bus.pc_o, 32'h300);
    for (int c = 0; c < 4; c++) begin
      #2 chk("drain_valid", bus.fetchValid_o, 1'b0);
      cycle();
      chk("drain_miss", bus.miss_o, 1'b1);
      chk("drain_addr", bus.missAddr_o, 32'h80);
    end
    bus.icacheFill_i = 1;
    cycle();
    bus.icacheFill_i = 0;
    chk("fill_miss", bus.miss_o, 1'b0);
    chk("fill_pc", bus.pc_o, 32'h300);
    cycle();
    chk("refetch_pc", bus.pc_o, 32'h320);

    // decode-stage recovery with checkpoint restore
    bus.flagRecoverID_i = 1; bus.targetAddrID_i = 32'h500;
    bus.rasRestorePtr_i = 4'd3; bus.flagCallID_i = 1; bus.callPCID_i = 32'h88;
    cycle();
    chk("id_ptr", bus.rasPtr_o, 4'd4);
    chk("id_top", bus.rasTop_o, 32'h88);
    chk("id_pc", bus.pc_o, 32'h500);
    bus.flagCallID_i = 0; bus.flagRtrID_i = 1; bus.rasRestorePtr_i = 4'd4;
    cycle();
    chk("id_rtr_pc", bus.pc_o, 32'h88);
    chk("id_rtr_ptr", bus.rasPtr_o, 4'd3);
    clear_inputs();

    // stall holds the PC, EX redirect still lands while stalled
    bus.stall_i = 1;
    cycle();
    cycle();
    chk("stall_hold", bus.pc_o, 32'h88);
    bus.flagRecoverEX_i = 1; bus.targetAddrEX_i = 32'h700;
    cycle();
    chk("stall_ex", bus.pc_o, 32'h700);
    clear_inputs();

    // reset during a miss abandons the outstanding fill
    bus.icacheMiss_i = 1;
    cycle();
    bus.icacheMiss_i = 0;
    reset = 1;
    cycle();
    reset = 0;
    chk("rst_miss", bus.miss_o, 1'b0);
    chk("rst_pc", bus.pc_o, 32'h0);
    bus.icacheFill_i = 1;
    cycle();
    bus.icacheFill_i = 0;
    chk("rst_fill_pc", bus.pc_o, 32'h20);

    for (int r = 0; r < 600; r++) begin
      int kind;
      clear_inputs();
      bus.stall_i = ($urandom_range(0, 4) == 0);
      bus.icacheMiss_i = ($urandom_range(0, 6) == 0);
      bus.icacheFill_i = ($urandom_range(0, 4) == 0);
      bus.btbHit_i = 4'($urandom);
      bus.btbCtrlType_i = 8'($urandom);
      bus.prediction_i = 4'($urandom);
      bus.btbTarget_i = {$urandom, $urandom, $urandom, $urandom};
      kind = $urandom_range(0, 19);
      case (kind)
        0: begin bus.recoverFlag_i = 1; bus.recoverPC_i = $urandom; end
        1: begin bus.exceptionFlag_i = 1; bus.exceptionPC_i = $urandom; end
        2, 3: begin bus.flagRecoverEX_i = 1; bus.targetAddrEX_i = $urandom; end
        4, 5: begin
          bus.flagRecoverID_i = 1;
          bus.targetAddrID_i = $urandom;
          bus.rasRestorePtr_i = 4'($urandom);
          bus.callPCID_i = $urandom;
          case ($urandom_range(0, 2))
            0: bus.flagCallID_i = 1;
            1: bus.flagRtrID_i = 1;
            default: ;
          endcase
        end
        default: ;
      endcase
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/fetch_pc_gen.md
Name: fetch_pc_gen

Overview:
- Parametrised next-PC generator for the fetch front end. Owns the PC register, a circular return address stack (RAS) with checkpoint restore, and an I-cache miss-wait state machine.
- Consumes per-slot BTB and branch-predictor results for a FETCH_WIDTH-wide fetch block and produces the fetch PC, a valid-slot mask and the miss request.
- Generalises the fixed 4-wide fetch to any power-of-two width. Adds support for unaligned fetch starts and miss/redirect sequencing.

Parameters:
- FETCH_WIDTH, 4, instructions per fetch block (power of two, >=2)
- SIZE_PC, 32, PC width in bits
- INST_BYTES, 8, bytes per instruction (power of two)
- RAS_DEPTH, 16, RAS entries (power of two)
- RESET_PC, 0, PC value loaded on reset

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- stall_i  in  1  back-end stall; holds PC and RAS
- recoverFlag_i  in  1  commit-time recovery
- recoverPC_i  in  SIZE_PC  recovery target
- exceptionFlag_i  in  1  exception redirect
- exceptionPC_i  in  SIZE_PC  exception target
- flagRecoverEX_i  in  1  execute-stage mispredict
- targetAddrEX_i  in  SIZE_PC  execute-stage target
- flagRecoverID_i  in  1  decode-stage mispredict
- targetAddrID_i  in  SIZE_PC  decode-stage target
- rasRestorePtr_i  in  log2(RAS_DEPTH)  checkpointed RAS pointer for decode-stage recovery
- flagCallID_i  in  1  BTB-missed call at decode
- callPCID_i  in  SIZE_PC  return address to push for that call
- flagRtrID_i  in  1  BTB-missed return at decode
- btbHit_i  in  FETCH_WIDTH  per-slot BTB hit
- btbCtrlType_i  in  2*FETCH_WIDTH  per-slot type: 00 return, 01 call, 10 jump, 11 conditional
- btbTarget_i  in  FETCH_WIDTH*SIZE_PC  per-slot target
- prediction_i  in  FETCH_WIDTH  per-slot taken prediction
- icacheMiss_i  in  1  miss on current PC
- icacheFill_i  in  1  fill complete pulse
- pc_o  out  SIZE_PC  current PC
- fetchValid_o  out  1  current block valid for decode
- fetchMask_o  out  FETCH_WIDTH  valid slots in current block
- rasPtr_o  out  log2(RAS_DEPTH)  RAS top-of-stack pointer, used as checkpoint
- rasTop_o  out  SIZE_PC  RAS top entry
- miss_o  out  1  miss request outstanding
- missAddr_o  out  SIZE_PC  block-aligned miss address

Behaviour:
- **Block geometry.**
  - BLK = FETCH_WIDTH*INST_BYTES.
  - base = PC with its low log2(BLK) bits cleared.
  - start = PC[log2(INST_BYTES) +: log2(FETCH_WIDTH)].
- **Slot taken rule.** taken[i] = btbHit_i[i] & (prediction_i[i] | type[i]!=11) & (i>=start).
  - k = lowest taken index.
- **fetchMask_o.** Bits start..k are set; if no slot is taken, bits start..FETCH_WIDTH-1 are set. The mask is combinational.
- **nextPC priority (highest first).**
  1. EX: targetAddrEX_i.
  2. ID: rasTop at rasRestorePtr_i if flagRtrID_i, else targetAddrID_i.
  3. Slot k: rasTop_o if type 00, else btbTarget_i[k].
  4. Otherwise: base+BLK, wrapping modulo 2^SIZE_PC.
- **PC register update order.**
  1. reset: RESET_PC.
  2. recoverFlag_i: recoverPC_i.
  3. exceptionFlag_i: exceptionPC_i.
  4. flagRecoverEX_i: nextPC, even when stalled.
  5. ~stall_i and state RUN and ~icacheMiss_i: nextPC.
  6. Otherwise: hold.
- **RAS: circular storage with a count (0..RAS_DEPTH).**
  - Speculative updates fire only on a cycle where the PC advances from RUN.
  - Slot-k call: push base+(k+1)*INST_BYTES.
  - Slot-k return: pop.
  - Push when full: overwrites the oldest entry; count stays at RAS_DEPTH.
  - Pop when empty: pointer decrements and wraps, count stays 0, and the stale entry is used.
- **RAS on decode-stage recovery (not stalled).**
  - Pointer is set to rasRestorePtr_i.
  - Then, if flagCallID_i, callPCID_i is pushed.
  - If flagRtrID_i, one entry is popped.
  - The restore happens in the same cycle as the push or pop.
- **RAS on recoverFlag_i or exceptionFlag_i.** Pointer and count are cleared to 0; entry contents are kept.
- **RAS on execute-stage recovery.** No RAS change.
- **State machine.**
  - RUN:
    - icacheMiss_i & ~stall_i & no redirect -> MISS_WAIT. miss_o=1 and missAddr_o=base are registered.
  - MISS_WAIT:
    - icacheFill_i -> RUN; the same PC is re-fetched.
    - Any redirect (recover, exception, EX, ID) -> DRAIN. PC takes the redirect target.
  - DRAIN:
    - Stale fill still outstanding; miss_o stays 1 and missAddr_o holds the old block.
    - icacheFill_i -> RUN.
    - Further redirects update the PC only.
  - Fill and redirect in the same cycle in MISS_WAIT -> RUN with the redirect PC.
- **fetchValid_o** = state==RUN & ~icacheMiss_i & ~stall_i.
- **Reset values.**
  - pc_o = RESET_PC, state RUN, miss_o = 0, missAddr_o = 0.
  - rasPtr_o = 0, count 0, and all RAS entries 0, so rasTop_o = 0.
  - fetchMask_o and fetchValid_o follow the combinational equations.
- **Reset mid-miss** returns to RUN immediately; the outstanding fill is ignored.

Test Plan:
- All defaults, reset, no hits, PC=0 -> PC sequence 0x00, 0x20, 0x40. fetchMask_o=4'b1111.
- PC=0x48 (start=1), slot 2 conditional predicted taken, target 0x100 -> fetchMask_o=4'b0110, next PC=0x100.
- PC=0x40, slot 1 call to 0x200, then return at 0x200 slot 0 -> push 0x50; next PCs are 0x200 then 0x50; rasPtr_o goes 0->1->0.
- 17 consecutive calls with RAS_DEPTH=16, then 17 returns -> first 16 returns yield addresses in LIFO order; the 17th yields the wrapped stale entry; count stays 0.
- Miss at 0x80, redirect EX to 0x300 during MISS_WAIT, fill 5 cycles later -> state DRAIN, miss_o=1 and missAddr_o=0x80 until the fill, then RUN fetching 0x300.
- ID recovery with rasRestorePtr_i=3, flagCallID_i=1, callPCID_i=0x88 -> rasPtr_o=4, rasTop_o=0x88, PC=targetAddrID_i.
